// File: rtl/fetch_queue_unit.sv
// Instruction fetch stage with a small decoupling queue.
// Handles redirect squash, I-cache handshake and decode back-pressure.
module fetch_queue_unit #(
  parameter int PC_W            = 64,
  parameter int INST_W          = 32,
  parameter int DEPTH           = 4,
  parameter int LINE_WORDS_LOG2 = 4
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic [PC_W-1:0]               entry,
  input  logic                          redirect_valid,
  input  logic [PC_W-1:0]               redirect_pc,
  output logic                          ic_req,
  output logic [PC_W-LINE_WORDS_LOG2-3:0] ic_line_addr,
  output logic [LINE_WORDS_LOG2-1:0]    ic_word_select,
  input  logic                          ic_ack,
  input  logic [INST_W-1:0]             ic_data,
  output logic                          id_valid,
  input  logic                          id_ready,
  output logic [INST_W-1:0]             id_inst,
  output logic [PC_W-1:0]               id_pcplus4,
  output logic [$clog2(DEPTH):0]        fq_count
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;
  localparam logic [CW-1:0] FULL = CW'(DEPTH);

  localparam logic [1:0] S_BOOT  = 2'd0;
  localparam logic [1:0] S_FETCH = 2'd1;
  localparam logic [1:0] S_HOLD  = 2'd2;
  localparam logic [1:0] S_FLUSH = 2'd3;

  logic [1:0]        state;
  logic [1:0]        state_nx;
  logic [PC_W-1:0]   fetch_pc;
  logic [PC_W-1:0]   pc_nx;
  logic [PC_W-1:0]   pc_plus4;
  logic [PC_W-1:0]   redir_pc;
  logic [INST_W-1:0] inst_q [DEPTH];
  logic [PC_W-1:0]   pc4_q  [DEPTH];
  logic [PW-1:0]     rd_ptr;
  logic [PW-1:0]     wr_ptr;
  logic [CW-1:0]     count;
  logic [CW-1:0]     count_nx;
  logic              push;
  logic              pop;

  assign pc_plus4 = fetch_pc + PC_W'(4);
  assign redir_pc = {redirect_pc[PC_W-1:2], 2'b00};

  assign ic_req = (state == S_FETCH) ||
                  (state == S_FLUSH);
  assign ic_line_addr =
    fetch_pc[PC_W-1:LINE_WORDS_LOG2+2];
  assign ic_word_select =
    fetch_pc[LINE_WORDS_LOG2+1:2];

  assign id_valid   = (count != '0);
  assign id_inst    = inst_q[rd_ptr];
  assign id_pcplus4 = pc4_q[rd_ptr];
  assign fq_count   = count;

  // a redirect discards any same-cycle push or pop
  assign push = (state == S_FETCH) && ic_ack &&
                !redirect_valid;
  assign pop  = id_valid && id_ready &&
                !redirect_valid;

  // occupancy after this cycle's push/pop
  always_comb begin
    count_nx = count;
    unique case ({push, pop})
      2'b10:   count_nx = count + CW'(1);
      2'b01:   count_nx = count - CW'(1);
      default: count_nx = count;
    endcase
  end

  // next fetch state and fetch PC
  always_comb begin
    state_nx = state;
    pc_nx    = fetch_pc;
    if (state == S_BOOT) begin
      state_nx = S_FETCH;
      pc_nx    = redirect_valid ? redir_pc : entry;
    end else if (redirect_valid) begin
      pc_nx    = redir_pc;
      state_nx = (ic_req && !ic_ack) ? S_FLUSH
                                     : S_FETCH;
    end else begin
      unique case (state)
        S_FETCH: begin
          if (ic_ack) begin
            pc_nx = pc_plus4;
            if (count_nx == FULL)
              state_nx = S_HOLD;
          end
        end
        S_HOLD: begin
          if (count_nx != FULL)
            state_nx = S_FETCH;
        end
        S_FLUSH: begin
          if (ic_ack)
            state_nx = S_FETCH;
        end
        default: state_nx = state;
      endcase
    end
  end

  // fetch state and PC registers
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state    <= S_BOOT;
      fetch_pc <= '0;
    end else begin
      state    <= state_nx;
      fetch_pc <= pc_nx;
    end
  end

  // queue pointers and occupancy
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else if (redirect_valid) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else begin
      if (push)
        wr_ptr <= wr_ptr + PW'(1);
      if (pop)
        rd_ptr <= rd_ptr + PW'(1);
      count <= count_nx;
    end
  end

  // queue storage, zeroed so outputs read 0 in reset
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < DEPTH; i++) begin
        inst_q[i] <= '0;
        pc4_q[i]  <= '0;
      end
    end else if (push) begin
      inst_q[wr_ptr] <= ic_data;
      pc4_q[wr_ptr]  <= pc_plus4;
    end
  end

  a_no_overflow: assert property (
    @(posedge clk) disable iff (reset)
    !(push && !pop && count == FULL));

endmodule

// File: tb/tb_fetch_queue_unit.sv
// Randomized bench for fetch_queue_unit.
// Reference model: a queue of fetched entries plus fetch PC.
module tb_fetch_queue_unit;

  localparam int PC_W  = 64;
  localparam int INST_W = 32;
  localparam int DEPTH = 4;
  localparam int LWL   = 4;

  logic              clk = 1'b0;
  logic              reset = 1'b1;
  logic [PC_W-1:0]   entry = '0;
  logic              redirect_valid = 1'b0;
  logic [PC_W-1:0]   redirect_pc = '0;
  logic              ic_req;
  logic [PC_W-LWL-3:0] ic_line_addr;
  logic [LWL-1:0]    ic_word_select;
  logic              ic_ack = 1'b0;
  logic [INST_W-1:0] ic_data = '0;
  logic              id_valid;
  logic              id_ready = 1'b0;
  logic [INST_W-1:0] id_inst;
  logic [PC_W-1:0]   id_pcplus4;
  logic [2:0]        fq_count;

  always #5 clk = ~clk;

  fetch_queue_unit #(
    .PC_W(PC_W), .INST_W(INST_W),
    .DEPTH(DEPTH), .LINE_WORDS_LOG2(LWL)
  ) dut (
    .clk(clk), .reset(reset), .entry(entry),
    .redirect_valid(redirect_valid),
    .redirect_pc(redirect_pc),
    .ic_req(ic_req), .ic_line_addr(ic_line_addr),
    .ic_word_select(ic_word_select),
    .ic_ack(ic_ack), .ic_data(ic_data),
    .id_valid(id_valid), .id_ready(id_ready),
    .id_inst(id_inst), .id_pcplus4(id_pcplus4),
    .fq_count(fq_count)
  );

  typedef struct packed {
    logic [31:0] inst;
    logic [63:0] pc4;
  } ent_t;

  ent_t        mq[$];
  logic [63:0] m_pc;
  bit          m_boot;
  bit          m_drop;

  int n_chk = 0;
  int n_err = 0;
  int wait_cnt = 0;
  int a_min, a_max, rdy_pct, rdr_pct;

  task automatic chk(string tag, logic [63:0] got,
                     logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h",
               tag, got, exp);
    end
  endtask

  // cache is asked for data unless booting or the queue is full
  function automatic bit m_req();
    return !m_boot &&
           (m_drop || mq.size() < DEPTH);
  endfunction

  task automatic m_reset();
    mq.delete();
    m_pc   = '0;
    m_boot = 1'b1;
    m_drop = 1'b0;
    wait_cnt = 0;
  endtask

  task automatic check_outputs();
    logic [63:0] e_line;
    logic [63:0] e_word;
    e_line = m_pc >> 6;
    e_word = (m_pc >> 2) & 64'hF;
    chk("ic_req", 64'(ic_req), 64'(m_req()));
    chk("line", 64'(ic_line_addr), e_line);
    chk("word", 64'(ic_word_select), e_word);
    chk("valid", 64'(id_valid),
        64'(mq.size() != 0));
    chk("count", 64'(fq_count), 64'(mq.size()));
    if (mq.size() != 0) begin
      chk("inst", 64'(id_inst), 64'(mq[0].inst));
      chk("pc4", id_pcplus4, mq[0].pc4);
    end
  endtask

  task automatic drive();
    logic [31:0] r;
    if (m_req()) begin
      if (wait_cnt == 0) begin
        ic_ack = 1'b1;
        wait_cnt = $urandom_range(a_max, a_min);
      end else begin
        ic_ack = 1'b0;
        wait_cnt--;
      end
    end else begin
      ic_ack = 1'b0;
    end
    ic_data  = $urandom;
    id_ready = ($urandom_range(99, 0) < rdy_pct);
    redirect_valid =
      ($urandom_range(99, 0) < rdr_pct);
    r = $urandom;
    if (r[2:0] == 3'd0)
      redirect_pc = 64'hFFFF_FFFF_FFFF_FFF0 |
                    64'(r[7:4]);
    else
      redirect_pc = 64'(r[19:0]);
  endtask

  // advance the model across one clock edge
  task automatic step();
    bit   req;
    ent_t e;
    req = m_req();
    if (m_boot) begin
      m_pc = redirect_valid ?
             (redirect_pc & ~64'h3) : entry;
      m_boot = 1'b0;
    end else if (redirect_valid) begin
      mq.delete();
      m_pc   = redirect_pc & ~64'h3;
      m_drop = req && !ic_ack;
    end else begin
      if (mq.size() != 0 && id_ready)
        void'(mq.pop_front());
      if (req && ic_ack) begin
        if (m_drop) begin
          m_drop = 1'b0;
        end else begin
          e.inst = ic_data;
          e.pc4  = m_pc + 64'd4;
          mq.push_back(e);
          m_pc = m_pc + 64'd4;
        end
      end
    end
  endtask

  task automatic run(int cyc, int amin, int amax,
                     int rdy, int rdr);
    a_min = amin; a_max = amax;
    rdy_pct = rdy; rdr_pct = rdr;
    repeat (cyc) begin
      @(negedge clk);
      check_outputs();
      drive();
      step();
    end
  endtask

  task automatic check_zero(string tag);
    chk({tag, "_req"}, 64'(ic_req), 64'd0);
    chk({tag, "_line"}, 64'(ic_line_addr), 64'd0);
    chk({tag, "_word"}, 64'(ic_word_select), 64'd0);
    chk({tag, "_valid"}, 64'(id_valid), 64'd0);
    chk({tag, "_inst"}, 64'(id_inst), 64'd0);
    chk({tag, "_pc4"}, id_pcplus4, 64'd0);
    chk({tag, "_cnt"}, 64'(fq_count), 64'd0);
  endtask

  task automatic do_reset(logic [63:0] e);
    reset = 1'b1;
    entry = e;
    redirect_valid = 1'b0;
    ic_ack = 1'b0;
    id_ready = 1'b0;
    m_reset();
    @(negedge clk);
    @(negedge clk);
    check_zero("rst");
    reset = 1'b0;
    a_min = 0; a_max = 0;
    rdy_pct = 0; rdr_pct = 0;
    drive();
    step();
  endtask

  initial begin
    bit found;
    do_reset(64'h1000);
    run(60, 2, 2, 100, 0);
    run(30, 0, 0, 0, 0);
    run(300, 0, 0, 50, 0);
    run(1500, 0, 4, 60, 5);
    run(1500, 0, 1, 90, 12);
    run(800, 2, 5, 40, 20);

    do_reset(64'hFFFF_FFFF_FFFF_FFFC);
    run(60, 0, 2, 70, 0);

    do_reset(64'h1000);
    run(10, 3, 3, 100, 0);
    found = 1'b0;
    for (int i = 0; i < 500; i++) begin
      if (m_drop) begin
        found = 1'b1;
        break;
      end
      run(1, 3, 3, 100, 30);
    end
    chk("flush_reached", 64'(found), 64'd1);
    @(posedge clk);
    #2 reset = 1'b1;
    #1 check_zero("async");
    do_reset(64'h0000_0000_0040_0100);
    run(1500, 0, 3, 50, 8);

    $display("Result: errors=%0d of %0d checks",
             n_err, n_chk);
    $finish;
  end

endmodule
